// File: rtl/uart_pkg.sv
// uart_pkg: register map, CON bit positions, shared RX/TX state encoding and
// the baud divisor helper used by the UART MMIO controller.
package uart_pkg;

   localparam logic [3:0] ADDR_TXD = 4'h0;
   localparam logic [3:0] ADDR_RXD = 4'h4;
   localparam logic [3:0] ADDR_CON = 4'h8;

   localparam int CON_RX_VALID  = 0;
   localparam int CON_TX_BUSY   = 1;
   localparam int CON_OVERRUN   = 2;
   localparam int CON_FRAME_ERR = 3;
   localparam int CON_RX_IRQ_EN = 4;
   localparam int CON_TX_IRQ_EN = 5;
   localparam int CON_TX_DONE   = 6;
   localparam int CON_LOOPBACK  = 7;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } uart_state_e;

   // Rounded clock cycles per oversample tick.
   function automatic int calc_div(input int clk_freq, input int baud, input int oversample);
      return (clk_freq + (baud * oversample) / 2) / (baud * oversample);
   endfunction

endpackage

// File: rtl/uart_mmio_ctrl_if.sv
// uart_mmio_ctrl_if: single-cycle peripheral bus between the CPU and the UART.
interface uart_mmio_ctrl_if;
   logic        rd;
   logic        wr;
   logic [3:0]  addr;
   logic [31:0] wdata;
   logic [31:0] rdata;

   modport master (output rd, output wr, output addr, output wdata, input rdata);
   modport slave  (input rd, input wr, input addr, input wdata, output rdata);
endinterface

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: free-running divider, one-cycle tick each time it wraps.
module uart_baud_gen #(
   parameter int DIV = 326
) (
   input  logic clk,
   input  logic reset,
   output logic tick
);
   localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   // count 0..DIV-1 and wrap
   always_comb begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
   end

   // divider register
   always_ff @(posedge clk) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign tick = (cnt_q == LAST);
endmodule

// File: rtl/uart_mmio_ctrl.sv
// uart_mmio_ctrl: memory-mapped 8N1 UART (TXD 0x0, RXD 0x4, CON 0x8) with level irq.
// Build option UART_LOOPBACK_EN adds CON[7]: TX line looped into RX, txd held high.
//
// state | meaning (same encoding for RX and TX)
// IDLE  | RX: waiting for rxs low      TX: waiting for a TXD write
// START | RX: qualify start at mid-bit TX: driving start bit (0)
// DATA  | 8 data bits, LSB first, one per OVERSAMPLE ticks
// STOP  | RX: sample stop, commit/err  TX: driving stop bit (1), then tx_done
module uart_mmio_ctrl
   import uart_pkg::*;
#(
   parameter int CLK_FREQ   = 50000000,
   parameter int BAUD       = 9600,
   parameter int OVERSAMPLE = 16
) (
   input  logic            clk,
   input  logic            reset,
   uart_mmio_ctrl_if.slave bus,
   input  logic            rxd,
   output logic            txd,
   output logic            irq
);
   localparam int            DIV     = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
   localparam int            TW      = $clog2(OVERSAMPLE);
   localparam logic [TW-1:0] TC_FULL = TW'(OVERSAMPLE - 1);
   localparam logic [TW-1:0] TC_HALF = TW'(OVERSAMPLE / 2 - 1);

   logic tick;
   logic rd_rxd, wr_txd, wr_con;
   logic rx_in, loopback;
   logic rx_meta_q, rx_meta_d, rxs_q, rxs_d;

   uart_state_e   rx_state_q, rx_state_d, tx_state_q, tx_state_d;
   logic [TW-1:0] rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d;
   logic [2:0]    rx_bit_q, rx_bit_d, tx_bit_q, tx_bit_d;
   logic [7:0]    rx_shift_q, rx_shift_d, tx_shift_q, tx_shift_d;
   logic          tx_line_q, tx_line_d;
   logic          rx_commit, rx_ferr, tx_accept, tx_fin;

   logic [7:0]  rx_data_q, rx_data_d;
   logic        rx_valid_q, rx_valid_d, overrun_q, overrun_d, frame_err_q, frame_err_d;
   logic        rx_irq_en_q, rx_irq_en_d, tx_irq_en_q, tx_irq_en_d, tx_done_q, tx_done_d;
   logic        irq_q, irq_d;
   logic [31:0] con_rd;

   uart_baud_gen #(.DIV(DIV)) u_baud (
      .clk   (clk),
      .reset (reset),
      .tick  (tick)
   );

   assign rd_rxd = bus.rd && (bus.addr == ADDR_RXD);
   assign wr_txd = bus.wr && (bus.addr == ADDR_TXD);
   assign wr_con = bus.wr && (bus.addr == ADDR_CON);

`ifdef UART_LOOPBACK_EN
   logic loopback_q, loopback_d;
   logic unused_wdata;

   // CON[7] loopback enable
   always_comb begin
      loopback_d = wr_con ? bus.wdata[CON_LOOPBACK] : loopback_q;
   end

   // loopback register
   always_ff @(posedge clk) begin
      if (reset) loopback_q <= 1'b0;
      else       loopback_q <= loopback_d;
   end

   assign loopback     = loopback_q;
   assign rx_in        = loopback_q ? tx_line_q : rxd;
   assign txd          = loopback_q | tx_line_q;
   assign unused_wdata = ^bus.wdata[31:8];
`else
   logic unused_wdata;
   assign loopback     = 1'b0;
   assign rx_in        = rxd;
   assign txd          = tx_line_q;
   assign unused_wdata = ^bus.wdata[31:7];
`endif

   // two-flop synchronizer for the asynchronous serial input
   always_comb begin
      rx_meta_d = rx_in;
      rxs_d     = rx_meta_q;
   end

   // synchronizer registers (idle high)
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_meta_q <= 1'b1;
         rxs_q     <= 1'b1;
      end else begin
         rx_meta_q <= rx_meta_d;
         rxs_q     <= rxs_d;
      end
   end

   // RX next state: tick counter is a down-counter, action on terminal count
   always_comb begin
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_cnt_q;
      rx_bit_d   = rx_bit_q;
      rx_shift_d = rx_shift_q;
      rx_commit  = 1'b0;
      rx_ferr    = 1'b0;
      case (rx_state_q)
         ST_IDLE: begin
            if (!rxs_q) begin
               rx_state_d = ST_START;
               rx_cnt_d   = TC_HALF;
            end
         end
         ST_START: begin
            if (tick) begin
               if (rx_cnt_q != '0) begin
                  rx_cnt_d = rx_cnt_q - 1'b1;
               end else if (!rxs_q) begin
                  rx_state_d = ST_DATA;
                  rx_cnt_d   = TC_FULL;
                  rx_bit_d   = '0;
               end else begin
                  rx_state_d = ST_IDLE;
               end
            end
         end
         ST_DATA: begin
            if (tick) begin
               if (rx_cnt_q != '0) begin
                  rx_cnt_d = rx_cnt_q - 1'b1;
               end else begin
                  rx_shift_d = {rxs_q, rx_shift_q[7:1]};
                  rx_cnt_d   = TC_FULL;
                  if (rx_bit_q == 3'd7) rx_state_d = ST_STOP;
                  else                  rx_bit_d   = rx_bit_q + 1'b1;
               end
            end
         end
         ST_STOP: begin
            if (tick) begin
               if (rx_cnt_q != '0) begin
                  rx_cnt_d = rx_cnt_q - 1'b1;
               end else begin
                  rx_commit  = rxs_q;
                  rx_ferr    = !rxs_q;
                  rx_state_d = ST_IDLE;
               end
            end
         end
         default: rx_state_d = ST_IDLE;
      endcase
   end

   // RX state registers
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_state_q <= ST_IDLE;
         rx_cnt_q   <= '0;
         rx_bit_q   <= '0;
         rx_shift_q <= '0;
      end else begin
         rx_state_q <= rx_state_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_bit_q   <= rx_bit_d;
         rx_shift_q <= rx_shift_d;
      end
   end

   // TX next state; line level is registered from the next state to stay glitch-free
   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_cnt_q;
      tx_bit_d   = tx_bit_q;
      tx_shift_d = tx_shift_q;
      tx_accept  = 1'b0;
      tx_fin     = 1'b0;
      tx_line_d  = 1'b1;
      case (tx_state_q)
         ST_IDLE: begin
            if (wr_txd) begin
               tx_accept  = 1'b1;
               tx_state_d = ST_START;
               tx_shift_d = bus.wdata[7:0];
               tx_cnt_d   = TC_FULL;
            end
         end
         ST_START: begin
            if (tick) begin
               if (tx_cnt_q != '0) begin
                  tx_cnt_d = tx_cnt_q - 1'b1;
               end else begin
                  tx_state_d = ST_DATA;
                  tx_cnt_d   = TC_FULL;
                  tx_bit_d   = '0;
               end
            end
         end
         ST_DATA: begin
            if (tick) begin
               if (tx_cnt_q != '0) begin
                  tx_cnt_d = tx_cnt_q - 1'b1;
               end else begin
                  tx_shift_d = {1'b0, tx_shift_q[7:1]};
                  tx_cnt_d   = TC_FULL;
                  if (tx_bit_q == 3'd7) tx_state_d = ST_STOP;
                  else                  tx_bit_d   = tx_bit_q + 1'b1;
               end
            end
         end
         ST_STOP: begin
            if (tick) begin
               if (tx_cnt_q != '0) begin
                  tx_cnt_d = tx_cnt_q - 1'b1;
               end else begin
                  tx_state_d = ST_IDLE;
                  tx_fin     = 1'b1;
               end
            end
         end
         default: tx_state_d = ST_IDLE;
      endcase
      case (tx_state_d)
         ST_START: tx_line_d = 1'b0;
         ST_DATA:  tx_line_d = tx_shift_d[0];
         default:  tx_line_d = 1'b1;
      endcase
   end

   // TX state registers
   always_ff @(posedge clk) begin
      if (reset) begin
         tx_state_q <= ST_IDLE;
         tx_cnt_q   <= '0;
         tx_bit_q   <= '0;
         tx_shift_q <= '0;
         tx_line_q  <= 1'b1;
      end else begin
         tx_state_q <= tx_state_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_bit_q   <= tx_bit_d;
         tx_shift_q <= tx_shift_d;
         tx_line_q  <= tx_line_d;
      end
   end

   // status/control next values: hardware sets beat W1C clears and RXD reads
   always_comb begin
      rx_data_d   = rx_data_q;
      rx_valid_d  = rx_valid_q & ~rd_rxd;
      overrun_d   = overrun_q & ~(wr_con & bus.wdata[CON_OVERRUN]);
      frame_err_d = (frame_err_q & ~(wr_con & bus.wdata[CON_FRAME_ERR])) | rx_ferr;
      tx_done_d   = (tx_done_q & ~(wr_con & bus.wdata[CON_TX_DONE]) & ~tx_accept) | tx_fin;
      rx_irq_en_d = wr_con ? bus.wdata[CON_RX_IRQ_EN] : rx_irq_en_q;
      tx_irq_en_d = wr_con ? bus.wdata[CON_TX_IRQ_EN] : tx_irq_en_q;
      if (rx_commit) begin
         rx_data_d  = rx_shift_q;
         rx_valid_d = 1'b1;
         if (rx_valid_q && !rd_rxd) overrun_d = 1'b1;
      end
      irq_d = (rx_irq_en_d & rx_valid_d) | (tx_irq_en_d & tx_done_d);
   end

   // status/control registers
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_data_q   <= '0;
         rx_valid_q  <= 1'b0;
         overrun_q   <= 1'b0;
         frame_err_q <= 1'b0;
         tx_done_q   <= 1'b0;
         rx_irq_en_q <= 1'b0;
         tx_irq_en_q <= 1'b0;
         irq_q       <= 1'b0;
      end else begin
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         overrun_q   <= overrun_d;
         frame_err_q <= frame_err_d;
         tx_done_q   <= tx_done_d;
         rx_irq_en_q <= rx_irq_en_d;
         tx_irq_en_q <= tx_irq_en_d;
         irq_q       <= irq_d;
      end
   end

   assign irq = irq_q;

   // CON read image
   always_comb begin
      con_rd                = '0;
      con_rd[CON_RX_VALID]  = rx_valid_q;
      con_rd[CON_TX_BUSY]   = (tx_state_q != ST_IDLE);
      con_rd[CON_OVERRUN]   = overrun_q;
      con_rd[CON_FRAME_ERR] = frame_err_q;
      con_rd[CON_RX_IRQ_EN] = rx_irq_en_q;
      con_rd[CON_TX_IRQ_EN] = tx_irq_en_q;
      con_rd[CON_TX_DONE]   = tx_done_q;
      con_rd[CON_LOOPBACK]  = loopback;
   end

   // read mux, zero when not reading
   always_comb begin
      bus.rdata = '0;
      if (bus.rd) begin
         case (bus.addr)
            ADDR_RXD: bus.rdata = {24'b0, rx_data_q};
            ADDR_CON: bus.rdata = con_rd;
            default:  bus.rdata = '0;
         endcase
      end
   end
endmodule

// File: tb/tb_uart_mmio_ctrl.sv
// tb_uart_mmio_ctrl: directed bench for the UART controller at a fast line rate
// (DIV=4, so one bit is 64 cycles) to keep run time short.
module tb_uart_mmio_ctrl;
   import uart_pkg::*;

   localparam int CLK_FREQ = 50_000_000;
   localparam int BAUD     = 781_250;
   localparam int OS       = 16;
   localparam int DIV      = 4;          // (50e6 + 6.25e6) / 12.5e6 = 4
   localparam int BIT_CYC  = OS * DIV;   // 64

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic rxd = 1'b1;
   logic txd, irq;
   int   cyc = 0;
   int   errors = 0;
   int   checks = 0;

   uart_mmio_ctrl_if bus ();

   uart_mmio_ctrl #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(OS)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus),
      .rxd   (rxd),
      .txd   (txd),
      .irq   (irq)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // all bus tasks start and end on a falling edge
   task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
      bus.wr = 1'b1; bus.addr = a; bus.wdata = d;
      @(negedge clk);
      bus.wr = 1'b0; bus.wdata = '0;
   endtask

   task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
      bus.rd = 1'b1; bus.addr = a;
      #1 d = bus.rdata;
      @(negedge clk);
      bus.rd = 1'b0;
   endtask

   task automatic check_reg(input string tag, input logic [3:0] a, input logic [31:0] exp);
      logic [31:0] d;
      bus_read(a, d);
      check(tag, d, exp);
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   // 8N1 frame; a low stop bit is held for 3/4 bit so the line is high again
   // before the receiver could mistake its tail for a new start bit
   task automatic send_byte(input logic [7:0] b, input logic stop);
      rxd = 1'b0;
      repeat (BIT_CYC) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         repeat (BIT_CYC) @(negedge clk);
      end
      rxd = stop;
      if (stop) begin
         repeat (BIT_CYC) @(negedge clk);
      end else begin
         repeat (BIT_CYC * 3 / 4) @(negedge clk);
         rxd = 1'b1;
         repeat (BIT_CYC / 4) @(negedge clk);
      end
   endtask

   initial begin
      logic [31:0] d;
      logic [9:0]  tx_frame;
      int          w, sa, ca, cb, t0;
      logic        found;

      bus.rd = 1'b0; bus.wr = 1'b0; bus.addr = '0; bus.wdata = '0;

      // reset
      reset = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      check("rst_txd", {31'b0, txd}, 32'd1);
      check("rst_irq", {31'b0, irq}, 32'd0);
      check_reg("rst_con", ADDR_CON, 32'h0);
      check_reg("rst_rxd", ADDR_RXD, 32'h0);

      // CON[7]
      bus_write(ADDR_CON, 32'h80);
`ifdef UART_LOOPBACK_EN
      check_reg("con_b7", ADDR_CON, 32'h80);
`else
      check_reg("con_b7", ADDR_CON, 32'h00);
`endif
      bus_write(ADDR_CON, 32'h00);

      // receive 0x01
      send_byte(8'h01, 1'b1);
      repeat (8) @(negedge clk);
      check_reg("rx1_con", ADDR_CON, 32'h01);
      check("rx1_irq", {31'b0, irq}, 32'd0);
      check_reg("rx1_rxd", ADDR_RXD, 32'h01);
      check_reg("rx1_con_after", ADDR_CON, 32'h00);

      // transmit 0x4A with tx_irq_en
      bus_write(ADDR_CON, 32'h20);
      check_reg("tx_con_en", ADDR_CON, 32'h20);
      w = cyc + 1;
      bus_write(ADDR_TXD, 32'h4A);
      check("tx_start_txd", {31'b0, txd}, 32'd0);
      check_reg("tx_con_busy", ADDR_CON, 32'h22);
      tx_frame = {1'b1, 8'h4A, 1'b0};
      for (int k = 0; k < 10; k++) begin
         wait_until(w + 32 + BIT_CYC * k);
         check($sformatf("tx_bit%0d", k), {31'b0, txd}, {31'b0, tx_frame[k]});
         if (k == 2) bus_write(ADDR_TXD, 32'hFF);
      end
      wait_until(w + 600);
      check_reg("tx_con_late", ADDR_CON, 32'h22);
      check("tx_irq_late", {31'b0, irq}, 32'd0);
      wait_until(w + 650);
      check_reg("tx_con_done", ADDR_CON, 32'h60);
      check("tx_irq_done", {31'b0, irq}, 32'd1);
      check("tx_idle_txd", {31'b0, txd}, 32'd1);
      bus_write(ADDR_CON, 32'h60);
      check("tx_irq_w1c", {31'b0, irq}, 32'd0);
      check_reg("tx_con_w1c", ADDR_CON, 32'h20);
      bus_write(ADDR_CON, 32'h00);
      check_reg("tx_con_clr", ADDR_CON, 32'h00);

      // overrun: 0x55 then 0xAA without reading
      send_byte(8'h55, 1'b1);
      send_byte(8'hAA, 1'b1);
      repeat (8) @(negedge clk);
      check_reg("ovr_con", ADDR_CON, 32'h05);
      bus_write(ADDR_CON, 32'h04);
      check_reg("ovr_con_w1c", ADDR_CON, 32'h01);
      bus_write(ADDR_CON, 32'h10);
      check("ovr_irq_rx", {31'b0, irq}, 32'd1);
      check_reg("ovr_con_en", ADDR_CON, 32'h11);
      check_reg("ovr_rxd", ADDR_RXD, 32'hAA);
      check("ovr_irq_rd", {31'b0, irq}, 32'd0);
      bus_write(ADDR_CON, 32'h00);

      // framing error on 0x33
      send_byte(8'h33, 1'b0);
      repeat (2 * BIT_CYC) @(negedge clk);
      check_reg("ferr_con", ADDR_CON, 32'h08);
      check_reg("ferr_rxd_kept", ADDR_RXD, 32'hAA);
      bus_write(ADDR_CON, 32'h08);
      check_reg("ferr_con_w1c", ADDR_CON, 32'h00);

      // 3-tick glitch, then a good byte to prove the receiver is idle
      rxd = 1'b0;
      repeat (3 * DIV) @(negedge clk);
      rxd = 1'b1;
      repeat (2 * BIT_CYC) @(negedge clk);
      check_reg("glitch_con", ADDR_CON, 32'h00);
      send_byte(8'h3C, 1'b1);
      repeat (8) @(negedge clk);
      check_reg("post_glitch_con", ADDR_CON, 32'h01);
      check_reg("post_glitch_rxd", ADDR_RXD, 32'h3C);

      // collision: locate the commit cycle of frame A, then land an RXD read
      // on the commit of frame B sent a whole number of bits (and baud periods) later
      sa = cyc;
      fork send_byte(8'h96, 1'b1); join_none
      wait_until(sa + 9 * BIT_CYC);
      found = 1'b0;
      ca = 0;
      bus.rd = 1'b1; bus.addr = ADDR_CON;
      for (int i = 0; i < 2 * BIT_CYC && !found; i++) begin
         #1;
         if (bus.rdata[CON_RX_VALID]) begin
            found = 1'b1;
            ca = cyc;
         end else begin
            @(negedge clk);
         end
      end
      @(negedge clk);
      bus.rd = 1'b0;
      check("coll_a_seen", {31'b0, found}, 32'd1);
      wait_until(sa + 20 * BIT_CYC);
      fork send_byte(8'h69, 1'b1); join_none
      cb = ca + 20 * BIT_CYC;
      wait_until(cb - 1);
      bus.rd = 1'b1; bus.addr = ADDR_RXD;
      #1 d = bus.rdata;
      @(negedge clk);
      bus.rd = 1'b0;
      check("coll_rxd_old", d, 32'h96);
      check_reg("coll_con", ADDR_CON, 32'h01);
      check_reg("coll_rxd_new", ADDR_RXD, 32'h69);
      check_reg("coll_con_after", ADDR_CON, 32'h00);
      wait_until(sa + 32 * BIT_CYC);

      // reset in the middle of a TX frame and an RX frame
      bus_write(ADDR_TXD, 32'h00);
      t0 = cyc;
      fork send_byte(8'hFF, 1'b1); join_none
      repeat (200) @(negedge clk);
      check("mid_txd_low", {31'b0, txd}, 32'd0);
      reset = 1'b1;
      @(negedge clk);
      check("mid_rst_txd", {31'b0, txd}, 32'd1);
      reset = 1'b0;
      wait_until(t0 + 12 * BIT_CYC);
      check_reg("mid_rst_con", ADDR_CON, 32'h00);
      check_reg("mid_rst_rxd", ADDR_RXD, 32'h00);
      check("mid_rst_irq", {31'b0, irq}, 32'd0);
      check("mid_rst_txd_idle", {31'b0, txd}, 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/uart_mmio_ctrl.md
Name: uart_mmio_ctrl

Overview:
Memory-mapped UART controller on the pipelined MIPS CPU's peripheral bus. It sequences the serial receive and transmit paths on rxd/txd and exposes TX data, RX data and a control/status register. Interrupt requests go to the CPU's exception logic. The block is clocked from the 50 MHz system clock and runs 8N1 framing at 9600 baud by default.

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz
BAUD, 9600, line rate in bits per second
OVERSAMPLE, 16, sample ticks per bit; a power of two ≥ 8

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
rd  in  1  bus read strobe, one cycle per access
wr  in  1  bus write strobe, one cycle per access
addr  in  4  byte offset: 0x0 TXD, 0x4 RXD, 0x8 CON; other offsets read 0 and ignore writes
wdata  in  32  write data; only the low 8 bits are used
rdata  out  32  read data, combinational from addr while rd=1, else 0
rxd  in  1  serial input; asynchronous, idle high
txd  out  1  serial output; idle high
irq  out  1  level interrupt request

Behaviour:
- Reset values: txd=1, irq=0, both FSMs IDLE, rx_data=0, and all CON bits 0 (rdata(CON)=0).
- Baud tick: DIV = (CLK_FREQ + BAUD*OVERSAMPLE/2) / (BAUD*OVERSAMPLE), which is 326 at the defaults. The counter is free-running from 0 to DIV-1. tick is a one-cycle pulse on wrap, so one bit lasts 16*326 = 5216 cycles.
- rxd passes through a 2-flop synchronizer, rxs. All RX decisions use rxs.
- RX FSM:
  - IDLE→START when rxs=0. The tick counter is cleared on entry.
  - START: at tick 8, go to DATA if rxs=0; if rxs=1 the start was a glitch, go to IDLE.
  - DATA: sample every 16 ticks, LSB first. After 8 bits go to STOP.
  - STOP: sample after 16 ticks.
    - If rxs=1: rx_data←byte and rx_valid←1. If rx_valid was already 1, also set overrun; the new byte overwrites.
    - If rxs=0: set frame_err and discard the byte.
    - Either way, return to IDLE.
- TX FSM:
  - IDLE: a write to TXD latches wdata[7:0], clears tx_done and goes to START. A write to TXD while busy is ignored.
  - START drives txd=0 for 16 ticks. DATA shifts 8 bits LSB first at 16 ticks each. STOP drives txd=1 for 16 ticks, then sets tx_done and returns to IDLE.
  - tx_busy = (state≠IDLE).
- CON bits:
  - b0 rx_valid: read-only.
  - b1 tx_busy: read-only.
  - b2 overrun: write 1 to clear.
  - b3 frame_err: write 1 to clear.
  - b4 rx_irq_en: read/write.
  - b5 tx_irq_en: read/write.
  - b6 tx_done: write 1 to clear.
  - b31..7 read 0.
- Reading RXD returns {24'b0, rx_data} and clears rx_valid on that edge.
- Simultaneous events:
  - RXD read in the same cycle as an RX stop-bit commit: the new byte wins. rx_valid stays 1 and no overrun is flagged.
  - W1C write in the same cycle as a flag set: the set wins.
- irq = (rx_irq_en & rx_valid) | (tx_irq_en & tx_done), driven from registers.
- Reset mid-frame: both FSMs return to IDLE and txd=1 on the next edge. A partial RX byte is discarded and no flag is set.

Optional Feature:
UART_LOOPBACK_EN
- Defined: CON b7 is loopback, read/write, reset 0. When it is 1, the RX synchronizer input is the internal TX serial line, and the external txd is held at 1.
- Undefined: b7 reads 0, writes to it are ignored, and there is no loopback mux.

Decomposition:
- Package uart_pkg holds:
  - register offsets (TXD/RXD/CON);
  - CON bit-index constants;
  - the shared RX/TX state encoding (IDLE/START/DATA/STOP);
  - a constant function computing DIV from CLK_FREQ, BAUD and OVERSAMPLE.
- Sub-module uart_baud_gen: the parameterised free-running divider that emits tick.
- The FSMs and register file stay in uart_mmio_ctrl.

Test Plan:
- Reset: hold reset=1 for 2 cycles, release → txd=1, CON reads 0x00000000, irq=0.
- RX: drive 0x01 as 8N1 with 104166.667 ns bits (matches the system-level bench), then read CON → 0x01. Read RXD → 0x00000001. Read CON again → 0x00.
- TX: write 0x4A to TXD → txd=0 for 5216 cycles, then bits 0,1,0,1,0,0,1,0, then stop=1. CON b1=1 for 52160 cycles, then b6=1. With tx_irq_en set, irq=1; W1C 0x40 drops irq.
- Overrun: receive 0x55 then 0xAA with no read → RXD=0xAA and CON=0x05. Write 0x04 to CON → CON=0x01.
- Framing and glitch:
  - Send 0x33 with stop bit driven 0 → CON b3=1, b0=0.
  - Pulse rxd low for 3 ticks only → RX FSM back in IDLE with no flags set.
- Collision: time an RXD read to land on the STOP commit cycle of the next byte → rx_valid stays 1, overrun=0.
